// File: rtl/axil_req_master_if.sv
// Bundle of request/response port and AXI4-Lite master channels for axil_req_master.
// master modport is the view of the bridge; slave modport is the view of whatever drives it.
interface axil_req_master_if #(
    parameter int AW = 32
) ();
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_wstrb;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          rsp_timeout;
    logic [15:0]   err_count;

    logic [AW-1:0] M_AXI_AWADDR;
    logic          M_AXI_AWVALID;
    logic [2:0]    M_AXI_AWPROT;
    logic          M_AXI_AWREADY;
    logic [31:0]   M_AXI_WDATA;
    logic [3:0]    M_AXI_WSTRB;
    logic          M_AXI_WVALID;
    logic          M_AXI_WREADY;
    logic [1:0]    M_AXI_BRESP;
    logic          M_AXI_BVALID;
    logic          M_AXI_BREADY;
    logic [AW-1:0] M_AXI_ARADDR;
    logic          M_AXI_ARVALID;
    logic [2:0]    M_AXI_ARPROT;
    logic          M_AXI_ARREADY;
    logic [31:0]   M_AXI_RDATA;
    logic [1:0]    M_AXI_RRESP;
    logic          M_AXI_RVALID;
    logic          M_AXI_RREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, err_count,
        output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_AWPROT,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARPROT,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_resp, rsp_timeout, err_count,
        input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_AWPROT,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_ARPROT,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axil_req_master.sv
// Single-outstanding AXI4-Lite master: one valid/ready request in, one valid/ready response out.
// Optional watchdog enabled by defining AXIL_TIMEOUT_EN.
module axil_req_master #(
    parameter int AW             = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    axil_req_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP} state_t;

    state_t        state_q;
    logic          awvalid_q, wvalid_q, arvalid_q;
    logic          bready_q, rready_q;
    logic [AW-1:0] awaddr_q, araddr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic [1:0]    rsp_resp_q;
    logic [15:0]   err_count_q;
    logic          aw_done_d, w_done_d;

`ifdef AXIL_TIMEOUT_EN
    // B/R ready idle high so beats arriving after a watchdog abort are swallowed.
    localparam logic        IDLE_RDY   = 1'b1;
    localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wdog_q;
    logic        rsp_timeout_q;
    logic        busy_d;
    assign busy_d = (state_q != IDLE) && (state_q != RESP);
`else
    localparam logic IDLE_RDY = 1'b0;
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] cnt, input logic [1:0] resp);
        return ((resp != 2'b00) && (cnt != 16'hFFFF)) ? cnt + 16'd1 : cnt;
    endfunction

    assign aw_done_d = !awvalid_q || bus.M_AXI_AWREADY;
    assign w_done_d  = !wvalid_q  || bus.M_AXI_WREADY;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            bready_q      <= 1'b0;
            rready_q      <= 1'b0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            err_count_q   <= '0;
`ifdef AXIL_TIMEOUT_EN
            wdog_q        <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    bready_q <= IDLE_RDY;
                    rready_q <= IDLE_RDY;
                    if (bus.req_valid) begin
                        bready_q <= 1'b0;
                        rready_q <= 1'b0;
                        if (bus.req_write) begin
                            awaddr_q  <= bus.req_addr;
                            wdata_q   <= bus.req_wdata;
                            wstrb_q   <= bus.req_wstrb;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WRITE;
                        end else begin
                            araddr_q  <= bus.req_addr;
                            arvalid_q <= 1'b1;
                            state_q   <= READ;
                        end
                    end
                end
                WRITE: begin
                    // AW and W complete independently, in either order or together.
                    if (bus.M_AXI_AWREADY) awvalid_q <= 1'b0;
                    if (bus.M_AXI_WREADY)  wvalid_q  <= 1'b0;
                    if (aw_done_d && w_done_d) begin
                        bready_q <= 1'b1;
                        state_q  <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (bus.M_AXI_BVALID) begin
                        rsp_resp_q  <= bus.M_AXI_BRESP;
                        rsp_rdata_q <= '0;
                        bready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        err_count_q <= sat_inc(err_count_q, bus.M_AXI_BRESP);
                        state_q     <= RESP;
                    end
                end
                READ: begin
                    if (bus.M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (bus.M_AXI_RVALID) begin
                        rsp_resp_q  <= bus.M_AXI_RRESP;
                        rsp_rdata_q <= bus.M_AXI_RDATA;
                        rready_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        err_count_q <= sat_inc(err_count_q, bus.M_AXI_RRESP);
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        bready_q    <= IDLE_RDY;
                        rready_q    <= IDLE_RDY;
`ifdef AXIL_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
`endif
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
`ifdef AXIL_TIMEOUT_EN
            // Watchdog expiry overrides whatever the bus-phase logic decided this cycle.
            if (state_q == IDLE && bus.req_valid) begin
                wdog_q <= '0;
            end else if (busy_d) begin
                if (wdog_q == WDOG_LIMIT) begin
                    awvalid_q     <= 1'b0;
                    wvalid_q      <= 1'b0;
                    arvalid_q     <= 1'b0;
                    bready_q      <= 1'b0;
                    rready_q      <= 1'b0;
                    rsp_resp_q    <= 2'b10;
                    rsp_rdata_q   <= '0;
                    rsp_timeout_q <= 1'b1;
                    rsp_valid_q   <= 1'b1;
                    err_count_q   <= sat_inc(err_count_q, 2'b10);
                    state_q       <= RESP;
                end else begin
                    wdog_q <= wdog_q + 16'd1;
                end
            end
`endif
        end
    end

    assign bus.req_ready     = (state_q == IDLE);
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_rdata     = rsp_rdata_q;
    assign bus.rsp_resp      = rsp_resp_q;
    assign bus.err_count     = err_count_q;
`ifdef AXIL_TIMEOUT_EN
    assign bus.rsp_timeout   = rsp_timeout_q;
`else
    assign bus.rsp_timeout   = 1'b0;
`endif
    assign bus.M_AXI_AWADDR  = awaddr_q;
    assign bus.M_AXI_AWVALID = awvalid_q;
    assign bus.M_AXI_AWPROT  = 3'b000;
    assign bus.M_AXI_WDATA   = wdata_q;
    assign bus.M_AXI_WSTRB   = wstrb_q;
    assign bus.M_AXI_WVALID  = wvalid_q;
    assign bus.M_AXI_BREADY  = bready_q;
    assign bus.M_AXI_ARADDR  = araddr_q;
    assign bus.M_AXI_ARVALID = arvalid_q;
    assign bus.M_AXI_ARPROT  = 3'b000;
    assign bus.M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_axil_req_master.sv
// Bench for axil_req_master: behavioural AXI4-Lite slave (adder at 0x8), directed requests,
// scoreboard queue of expected responses checked by an independent monitor.
module tb_axil_req_master;
    logic clk;
    logic reset;

    axil_req_master_if #(.AW(32)) bus ();

    axil_req_master #(.AW(32), .TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        tmo;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   accept_cyc = 0;
    int   first_cyc  = 0;

    // slave configuration and state
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    bit          ar_silent = 0;
    bit          inject_r  = 0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
    bit          aw_got = 0, w_got = 0;
    logic [31:0] mem [16];
    logic [31:0] last_awaddr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural AXI4-Lite slave: fires sampled at negedge, effects applied just after posedge.
    initial begin
        bit aw_f, w_f, b_f, ar_f, r_f, aw_wt, w_wt, ar_wt;
        logic [31:0] aw_a, w_d, ar_a;
        logic [3:0]  w_s;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        bus.M_AXI_AWREADY = 1'b1;
        bus.M_AXI_WREADY  = 1'b1;
        bus.M_AXI_ARREADY = 1'b1;
        bus.M_AXI_BVALID  = 1'b0;
        bus.M_AXI_BRESP   = 2'b00;
        bus.M_AXI_RVALID  = 1'b0;
        bus.M_AXI_RRESP   = 2'b00;
        bus.M_AXI_RDATA   = '0;
        forever begin
            @(negedge clk);
            aw_f  = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
            w_f   = bus.M_AXI_WVALID  && bus.M_AXI_WREADY;
            b_f   = bus.M_AXI_BVALID  && bus.M_AXI_BREADY;
            ar_f  = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
            r_f   = bus.M_AXI_RVALID  && bus.M_AXI_RREADY;
            aw_wt = bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY;
            w_wt  = bus.M_AXI_WVALID  && !bus.M_AXI_WREADY;
            ar_wt = bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY;
            aw_a  = bus.M_AXI_AWADDR;
            w_d   = bus.M_AXI_WDATA;
            w_s   = bus.M_AXI_WSTRB;
            ar_a  = bus.M_AXI_ARADDR;
            @(posedge clk);
            #1;
            if (reset) begin
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
                aw_got = 0; w_got = 0;
                bus.M_AXI_BVALID = 1'b0;
                bus.M_AXI_RVALID = 1'b0;
            end else begin
                if (aw_f) begin aw_got = 1; last_awaddr = aw_a; aw_cnt = 0; end
                else if (aw_wt) aw_cnt++;
                if (w_f) begin w_got = 1; last_wdata = w_d; last_wstrb = w_s; w_cnt = 0; end
                else if (w_wt) w_cnt++;
                if (b_f) begin
                    bus.M_AXI_BVALID = 1'b0;
                    aw_got = 0; w_got = 0;
                end else if (aw_got && w_got && !bus.M_AXI_BVALID) begin
                    for (int b = 0; b < 4; b++)
                        if (last_wstrb[b]) mem[last_awaddr[5:2]][8*b +: 8] = last_wdata[8*b +: 8];
                    bus.M_AXI_BRESP  = bresp_cfg;
                    bus.M_AXI_BVALID = 1'b1;
                end
                if (r_f) bus.M_AXI_RVALID = 1'b0;
                if (ar_f) begin
                    ar_cnt = 0;
                    if (ar_a == 32'h8)        bus.M_AXI_RDATA = mem[0] + mem[1];
                    else if (rresp_cfg != 0)  bus.M_AXI_RDATA = 32'hBAD0BAD0;
                    else                      bus.M_AXI_RDATA = mem[ar_a[5:2]];
                    bus.M_AXI_RRESP  = rresp_cfg;
                    bus.M_AXI_RVALID = 1'b1;
                end else if (ar_wt) ar_cnt++;
                if (inject_r) begin
                    bus.M_AXI_RDATA  = 32'h0000_1234;
                    bus.M_AXI_RRESP  = 2'b00;
                    bus.M_AXI_RVALID = 1'b1;
                    inject_r = 0;
                end
            end
            bus.M_AXI_AWREADY = (aw_delay == 0) || (aw_cnt >= aw_delay);
            bus.M_AXI_WREADY  = (w_delay == 0)  || (w_cnt >= w_delay);
            bus.M_AXI_ARREADY = !ar_silent && ((ar_delay == 0) || (ar_cnt >= ar_delay));
        end
    end

    // Response monitor and bus protocol checks.
    initial begin
        bit          prev_rv = 0, prev_awv = 0, prev_awf = 0, prev_arv = 0, prev_arf = 0;
        logic [31:0] prev_awa = '0, prev_ara = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (bus.rsp_valid && !prev_rv) first_cyc = cyc;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                    chk("rsp_resp", 32'(bus.rsp_resp), 32'(e.resp));
                    chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.tmo));
                    if (e.lat >= 0) chk("rsp_latency", 32'(first_cyc - accept_cyc), 32'(e.lat));
                end
            end
            if (!reset && !bus.req_ready && bus.M_AXI_BREADY)
                chk("bready_after_aw_w", 32'(aw_got && w_got), 32'h1);
            if (!reset && !bus.rsp_timeout && prev_awv && !prev_awf) begin
                chk("awvalid_hold", 32'(bus.M_AXI_AWVALID), 32'h1);
                chk("awaddr_hold", bus.M_AXI_AWADDR, prev_awa);
            end
            if (!reset && !bus.rsp_timeout && prev_arv && !prev_arf) begin
                chk("arvalid_hold", 32'(bus.M_AXI_ARVALID), 32'h1);
                chk("araddr_hold", bus.M_AXI_ARADDR, prev_ara);
            end
            prev_rv  = bus.rsp_valid;
            prev_awv = bus.M_AXI_AWVALID;
            prev_awf = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
            prev_awa = bus.M_AXI_AWADDR;
            prev_arv = bus.M_AXI_ARVALID;
            prev_arf = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
            prev_ara = bus.M_AXI_ARADDR;
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input bit push, input logic [31:0] exp_rdata,
                         input logic [1:0] exp_resp, input logic exp_tmo, input int exp_lat);
        exp_t e;
        if (push) begin
            e.rdata = exp_rdata; e.resp = exp_resp; e.tmo = exp_tmo; e.lat = exp_lat;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = strb;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                accept_cyc = cyc;
                @(posedge clk);
                #1;
                bus.req_valid = 1'b0;
                return;
            end
        end
        chk("req_accept_timeout", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && bus.req_ready) return;
        end
        chk("drain_timeout", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_watchdog: simulation did not complete");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        bit seen;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("rst_valids", {28'h0, bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID, bus.rsp_valid}, 32'h0);
        chk("rst_readies", {30'h0, bus.M_AXI_BREADY, bus.M_AXI_RREADY}, 32'h0);
        chk("rst_err_count", 32'(bus.err_count), 32'h0);
        chk("rst_rsp", {bus.rsp_rdata[29:0], bus.rsp_resp}, 32'h0);
        chk("rst_awaddr", bus.M_AXI_AWADDR, 32'h0);
        reset = 1'b0;

        // adder slave: two writes then sum read, minimum latency
        issue(1'b1, 32'h0, 32'd5, 4'hF, 1, 32'h0, 2'b00, 1'b0, 3);
        issue(1'b1, 32'h4, 32'd7, 4'hF, 1, 32'h0, 2'b00, 1'b0, 3);
        issue(1'b0, 32'h8, 32'h0, 4'h0, 1, 32'd12, 2'b00, 1'b0, 3);
        wait_idle();

        // AW early / W late, then the reverse with partial strobes
        w_delay = 3;
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'h0, 2'b00, 1'b0, -1);
        wait_idle();
        chk("bus_wdata", last_wdata, 32'hDEADBEEF);
        chk("bus_wstrb", 32'(last_wstrb), 32'hF);
        chk("bus_awaddr", last_awaddr, 32'h10);
        w_delay = 0; aw_delay = 3;
        issue(1'b1, 32'h14, 32'h12345678, 4'h3, 1, 32'h0, 2'b00, 1'b0, -1);
        wait_idle();
        aw_delay = 0;
        issue(1'b0, 32'h14, 32'h0, 4'h0, 1, 32'h00005678, 2'b00, 1'b0, 3);
        wait_idle();

        // error responses and err_count
        chk("err_count_before", 32'(bus.err_count), 32'h0);
        rresp_cfg = 2'b11;
        issue(1'b0, 32'h40, 32'h0, 4'h0, 1, 32'hBAD0BAD0, 2'b11, 1'b0, 3);
        wait_idle();
        rresp_cfg = 2'b00;
        chk("err_count_decerr", 32'(bus.err_count), 32'h1);
        issue(1'b0, 32'h0, 32'h0, 4'h0, 1, 32'd5, 2'b00, 1'b0, 3);
        wait_idle();
        chk("err_count_okay", 32'(bus.err_count), 32'h1);
        bresp_cfg = 2'b10;
        issue(1'b1, 32'h30, 32'h1, 4'hF, 1, 32'h0, 2'b10, 1'b0, 3);
        wait_idle();
        bresp_cfg = 2'b00;
        chk("err_count_slverr", 32'(bus.err_count), 32'h2);

        // response back-pressure
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        issue(1'b0, 32'h4, 32'h0, 4'h0, 1, 32'd7, 2'b00, 1'b0, 3);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.rsp_valid;
        end
        chk("bp_rsp_seen", 32'(seen), 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            chk("bp_rsp_rdata", bus.rsp_rdata, 32'd7);
            chk("bp_req_ready", 32'(bus.req_ready), 32'h0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_idle();

        // reset in the middle of a write with AWVALID pending
        aw_delay = 6;
        issue(1'b1, 32'h20, 32'h99, 4'hF, 0, 32'h0, 2'b00, 1'b0, -1);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.M_AXI_AWVALID;
        end
        chk("mid_awvalid_seen", 32'(seen), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_awvalid", 32'(bus.M_AXI_AWVALID), 32'h0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'h1);
        chk("mid_rst_err_count", 32'(bus.err_count), 32'h0);
        chk("mid_rst_awaddr", bus.M_AXI_AWADDR, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        aw_delay = 0;
        issue(1'b1, 32'h20, 32'h55, 4'hF, 1, 32'h0, 2'b00, 1'b0, 3);
        issue(1'b0, 32'h20, 32'h0, 4'h0, 1, 32'h55, 2'b00, 1'b0, 3);
        wait_idle();

`ifdef AXIL_TIMEOUT_EN
        // silent slave: watchdog response after 16 busy cycles, late R beat absorbed
        ar_silent = 1;
        issue(1'b0, 32'h0, 32'h0, 4'h0, 1, 32'h0, 2'b10, 1'b1, 17);
        wait_idle();
        ar_silent = 0;
        chk("tmo_err_count", 32'(bus.err_count), 32'h1);
        inject_r = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("late_r_no_rsp", 32'(bus.rsp_valid), 32'h0);
        end
        chk("late_r_absorbed", 32'(bus.M_AXI_RVALID), 32'h0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
